// File: rtl/vending_machine_if.sv
// rtl/vending_machine_if.sv - coin-mech/keypad inputs and dispenser/hopper outputs
interface vending_machine_if;
   logic [15:0] money_input;
   logic        swa, swb, swc, swd;
   logic        sw1, sw2, sw3, sw4;
   logic [15:0] change;
   logic [15:0] price;
   logic [3:0]  selection;
   logic        success;

   modport master (
      output money_input, swa, swb, swc, swd, sw1, sw2, sw3, sw4,
      input  change, price, selection, success
   );

   modport slave (
      input  money_input, swa, swb, swc, swd, sw1, sw2, sw3, sw4,
      output change, price, selection, success
   );
endinterface

// File: rtl/vending_machine.sv
// rtl/vending_machine.sv - coin-credit vending controller for a 4x4 item matrix
module vending_machine #(
   parameter int TIMEOUT_CYCLES = 100
) (
   input  logic         clk,
   input  logic         reset,
   vending_machine_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, CREDIT, ROW} state_t;

   state_t        state;
   logic [15:0]   credit;
   logic [15:0]   last_in;
   logic [1:0]    row_q;
   logic [3:0]    rows_q, cols_q;
   logic [CW-1:0] idle_cnt;
   logic          reset_q;

   logic [3:0]  rows, cols, row_rise, col_rise;
   logic        row_valid, col_valid;
   logic [1:0]  row_idx, col_idx;
   logic        coin;
   logic [16:0] credit_sum;
   logic [15:0] credit_next;
   logic [15:0] item_price;
   logic        activity, busy, timeout_fire;

   function automatic logic [1:0] enc4(input logic [3:0] v);
      case (v)
         4'b0010: enc4 = 2'd1;
         4'b0100: enc4 = 2'd2;
         4'b1000: enc4 = 2'd3;
         default: enc4 = 2'd0;
      endcase
   endfunction

   function automatic logic [15:0] base_price(input logic [1:0] r);
      case (r)
         2'd0:    base_price = 16'd100;
         2'd1:    base_price = 16'd250;
         2'd2:    base_price = 16'd75;
         default: base_price = 16'd50;
      endcase
   endfunction

   assign rows     = {bus.swd, bus.swc, bus.swb, bus.swa};
   assign cols     = {bus.sw4, bus.sw3, bus.sw2, bus.sw1};
   assign row_rise = rows & ~rows_q;
   assign col_rise = cols & ~cols_q;

   // A press counts only if it is the sole key of its group that is high.
   assign row_valid = $onehot(row_rise) && (rows == row_rise);
   assign col_valid = $onehot(col_rise) && (cols == col_rise);
   assign row_idx   = enc4(row_rise);
   assign col_idx   = enc4(col_rise);

   assign coin        = bus.money_input > last_in;
   assign credit_sum  = {1'b0, credit} + {1'b0, bus.money_input - last_in};
   assign credit_next = !coin ? credit : (credit_sum[16] ? 16'hFFFF : credit_sum[15:0]);
   assign item_price  = base_price(row_q) + 16'(col_idx) * 16'd25;

   assign activity     = coin || row_valid || col_valid;
   assign busy         = (credit != 16'd0) || (state == ROW);
   assign timeout_fire = !activity && busy && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      rows_q  <= rows;
      cols_q  <= cols;
      last_in <= bus.money_input;
      reset_q <= reset;
      if (reset) begin
         // Only the first reset cycle refunds; later cycles would see zero credit.
         if (!reset_q)
            bus.change <= credit;
         bus.success   <= 1'b0;
         bus.price     <= 16'd0;
         bus.selection <= 4'd0;
         credit        <= 16'd0;
         idle_cnt      <= '0;
         row_q         <= 2'd0;
         state         <= IDLE;
      end else begin
         credit <= credit_next;
         if (coin)
            bus.price <= 16'd0;

         if (activity || !busy || timeout_fire)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;

         if (row_valid) begin
            row_q <= row_idx;
            state <= ROW;
         end else if (col_valid && state == ROW) begin
            if (credit_next >= item_price) begin
               bus.success   <= 1'b1;
               bus.selection <= {row_q, col_idx};
               bus.change    <= credit_next - item_price;
               bus.price     <= 16'd0;
               credit        <= 16'd0;
               state         <= IDLE;
            end else begin
               bus.success <= 1'b0;
               bus.price   <= item_price;
               bus.change  <= 16'd0;
               state       <= (credit_next != 16'd0) ? CREDIT : IDLE;
            end
         end else if (timeout_fire) begin
            bus.change  <= credit;
            bus.success <= 1'b0;
            bus.price   <= 16'd0;
            credit      <= 16'd0;
            state       <= IDLE;
         end else if (state == IDLE && credit_next != 16'd0) begin
            state <= CREDIT;
         end
      end
   end
endmodule

// File: tb/tb_vending_machine.sv
// tb/tb_vending_machine.sv - randomized and directed checks against a behavioural model
module tb_vending_machine;
   localparam int T = 16;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   vending_machine_if vm();

   vending_machine #(.TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vm)
   );

   always #5 clk = ~clk;

   int       m_credit, m_row, m_idle, m_last;
   int       m_change, m_price, m_sel;
   bit       m_succ, m_rst_prev;
   bit [3:0] m_rprev, m_cprev;

   function automatic int first_set(input bit [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_edge();
      bit [3:0] r, c, rr, cr;
      bit rv, cv, coin, busy;
      int money, p;
      int bases[4] = '{100, 250, 75, 50};
      r     = {vm.swd, vm.swc, vm.swb, vm.swa};
      c     = {vm.sw4, vm.sw3, vm.sw2, vm.sw1};
      rr    = r & ~m_rprev;
      cr    = c & ~m_cprev;
      rv    = ($countones(rr) == 1) && ($countones(r) == 1);
      cv    = ($countones(cr) == 1) && ($countones(c) == 1);
      money = int'(vm.money_input);
      coin  = money > m_last;
      if (reset) begin
         if (!m_rst_prev) m_change = m_credit;
         m_succ = 0; m_price = 0; m_sel = 0;
         m_credit = 0; m_row = -1; m_idle = 0;
      end else begin
         busy = (m_credit > 0) || (m_row >= 0);
         if (coin) begin
            m_credit = m_credit + money - m_last;
            if (m_credit > 65535) m_credit = 65535;
            m_price = 0;
         end
         if (rv) begin
            m_row = first_set(rr);
         end else if (cv && m_row >= 0) begin
            p = bases[m_row] + 25 * first_set(cr);
            if (m_credit >= p) begin
               m_succ = 1; m_sel = m_row * 4 + first_set(cr);
               m_change = m_credit - p; m_price = 0; m_credit = 0;
            end else begin
               m_succ = 0; m_price = p; m_change = 0;
            end
            m_row = -1;
         end
         if (coin || rv || cv || !busy) begin
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == T) begin
               m_change = m_credit; m_succ = 0; m_price = 0;
               m_credit = 0; m_row = -1; m_idle = 0;
            end
         end
      end
      m_rst_prev = reset;
      m_last = money;
      m_rprev = r;
      m_cprev = c;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic release_keys();
      {vm.swa, vm.swb, vm.swc, vm.swd} = 4'b0;
      {vm.sw1, vm.sw2, vm.sw3, vm.sw4} = 4'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      vm.money_input = 16'd0;
      release_keys();
      cyc(); cyc();
      checks++; if (vm.success !== 1'b0) begin failures++; $display("FAIL reset_success got=%0d exp=0", vm.success); end
      checks++; if (vm.price !== 16'd0) begin failures++; $display("FAIL reset_price got=%0d exp=0", vm.price); end
      checks++; if (vm.selection !== 4'd0) begin failures++; $display("FAIL reset_selection got=%0d exp=0", vm.selection); end
      reset = 1'b0; cyc();
      reset = 1'b1; cyc();
      checks++; if (vm.change !== 16'd0) begin failures++; $display("FAIL reset_change_nocredit got=%0d exp=0", vm.change); end
      reset = 1'b0; cyc();
   endtask

   task automatic test_exact_change();
      vm.money_input = 16'd25;  cyc();
      vm.money_input = 16'd50;  cyc();
      vm.money_input = 16'd75;  cyc();
      vm.money_input = 16'd100; cyc();
      vm.swa = 1'b1; cyc();
      vm.swa = 1'b0; vm.sw1 = 1'b1; cyc();
      checks++; if (vm.success !== 1'b1) begin failures++; $display("FAIL exact_success got=%0d exp=1", vm.success); end
      checks++; if (vm.selection !== 4'd0) begin failures++; $display("FAIL exact_selection got=%0d exp=0", vm.selection); end
      checks++; if (vm.change !== 16'd0) begin failures++; $display("FAIL exact_change got=%0d exp=0", vm.change); end
      checks++; if (vm.price !== 16'd0) begin failures++; $display("FAIL exact_price got=%0d exp=0", vm.price); end
      vm.sw1 = 1'b0; cyc();
   endtask

   task automatic test_dispense_change();
      vm.money_input = 16'd0;   cyc();
      vm.money_input = 16'd200; cyc();
      vm.swa = 1'b1; cyc();
      vm.swa = 1'b0; vm.sw3 = 1'b1; cyc();
      checks++; if (vm.success !== 1'b1) begin failures++; $display("FAIL dispense_success got=%0d exp=1", vm.success); end
      checks++; if (vm.selection !== 4'd2) begin failures++; $display("FAIL dispense_selection got=%0d exp=2", vm.selection); end
      checks++; if (vm.change !== 16'd50) begin failures++; $display("FAIL dispense_change got=%0d exp=50", vm.change); end
      vm.sw3 = 1'b0; cyc();
   endtask

   task automatic test_invalid_selection();
      vm.money_input = 16'd0;   cyc();
      vm.money_input = 16'd200; cyc();
      vm.swa = 1'b1; vm.swb = 1'b1; cyc();
      vm.swa = 1'b0; vm.swb = 1'b0; cyc();
      vm.sw1 = 1'b1; cyc();
      checks++; if (vm.success !== 1'b1) begin failures++; $display("FAIL invalid_success got=%0d exp=1", vm.success); end
      checks++; if (vm.selection !== 4'd2) begin failures++; $display("FAIL invalid_selection got=%0d exp=2", vm.selection); end
      checks++; if (vm.change !== 16'd50) begin failures++; $display("FAIL invalid_change got=%0d exp=50", vm.change); end
      vm.sw1 = 1'b0; cyc();
   endtask

   task automatic test_insufficient();
      vm.swb = 1'b1; cyc();
      vm.swb = 1'b0; vm.sw1 = 1'b1; cyc();
      checks++; if (vm.success !== 1'b0) begin failures++; $display("FAIL short_success got=%0d exp=0", vm.success); end
      checks++; if (vm.price !== 16'd250) begin failures++; $display("FAIL short_price got=%0d exp=250", vm.price); end
      checks++; if (vm.change !== 16'd0) begin failures++; $display("FAIL short_change got=%0d exp=0", vm.change); end
      vm.sw1 = 1'b0; vm.money_input = 16'd250; cyc();
      checks++; if (vm.price !== 16'd0) begin failures++; $display("FAIL coin_clears_price got=%0d exp=0", vm.price); end
      vm.swb = 1'b1; cyc();
      vm.swb = 1'b0; vm.sw1 = 1'b1; cyc();
      checks++; if (vm.success !== 1'b1) begin failures++; $display("FAIL topup_success got=%0d exp=1", vm.success); end
      checks++; if (vm.change !== 16'd0) begin failures++; $display("FAIL topup_change got=%0d exp=0", vm.change); end
      checks++; if (vm.selection !== 4'd4) begin failures++; $display("FAIL topup_selection got=%0d exp=4", vm.selection); end
      vm.sw1 = 1'b0; cyc();
   endtask

   task automatic test_timeout();
      vm.money_input = 16'd0;   cyc();
      vm.money_input = 16'd100; cyc();
      repeat (T - 1) cyc();
      checks++; if (vm.change !== 16'd0) begin failures++; $display("FAIL timeout_early got=%0d exp=0", vm.change); end
      cyc();
      checks++; if (vm.change !== 16'd100) begin failures++; $display("FAIL timeout_change got=%0d exp=100", vm.change); end
      checks++; if (vm.success !== 1'b0) begin failures++; $display("FAIL timeout_success got=%0d exp=0", vm.success); end
      vm.money_input = 16'd0;  cyc();
      vm.money_input = 16'd60; cyc();
      vm.swc = 1'b1; cyc();
      vm.swc = 1'b0;
      repeat (T - 1) cyc();
      checks++; if (vm.change !== 16'd100) begin failures++; $display("FAIL row_timeout_early got=%0d exp=100", vm.change); end
      cyc();
      checks++; if (vm.change !== 16'd60) begin failures++; $display("FAIL row_timeout_change got=%0d exp=60", vm.change); end
   endtask

   task automatic test_reset_refund();
      vm.money_input = 16'd0;   cyc();
      vm.money_input = 16'd100; cyc();
      cyc(); cyc();
      reset = 1'b1; cyc();
      checks++; if (vm.change !== 16'd100) begin failures++; $display("FAIL rst_refund got=%0d exp=100", vm.change); end
      checks++; if (vm.success !== 1'b0) begin failures++; $display("FAIL rst_success got=%0d exp=0", vm.success); end
      checks++; if (vm.selection !== 4'd0) begin failures++; $display("FAIL rst_selection got=%0d exp=0", vm.selection); end
      cyc();
      checks++; if (vm.change !== 16'd100) begin failures++; $display("FAIL rst_hold_refund got=%0d exp=100", vm.change); end
      reset = 1'b0; cyc();
      vm.swd = 1'b1; cyc();
      vm.swd = 1'b0; vm.sw1 = 1'b1; cyc();
      checks++; if (vm.price !== 16'd50) begin failures++; $display("FAIL rst_no_recount_price got=%0d exp=50", vm.price); end
      checks++; if (vm.success !== 1'b0) begin failures++; $display("FAIL rst_no_recount_success got=%0d exp=0", vm.success); end
      vm.sw1 = 1'b0; cyc();
   endtask

   task automatic test_random();
      int quiet = 0;
      int k, m, a;
      for (int i = 0; i < 1500; i++) begin
         if (quiet > 0) begin
            quiet--;
            reset = 1'b0;
         end else begin
            a = $urandom_range(0, 99);
            reset = (a < 2);
            if (a == 50) quiet = T + 3;
            k = $urandom_range(0, 9);
            case (k)
               0, 1, 2, 3: release_keys();
               4: begin release_keys(); {vm.swd, vm.swc, vm.swb, vm.swa} = 4'b1 << $urandom_range(0, 3); end
               5: begin release_keys(); {vm.sw4, vm.sw3, vm.sw2, vm.sw1} = 4'b1 << $urandom_range(0, 3); end
               6: begin release_keys(); vm.swa = 1'b1; vm.swd = 1'b1; end
               7: begin release_keys(); vm.sw2 = 1'b1; vm.sw3 = 1'b1; end
               8: begin release_keys(); vm.swb = 1'b1; vm.sw4 = 1'b1; end
               default: ;
            endcase
            m = $urandom_range(0, 19);
            if (m < 6)
               vm.money_input = vm.money_input + 16'($urandom_range(5, 100));
            else if (m == 6)
               vm.money_input = vm.money_input - 16'($urandom_range(1, 30));
            else if (m == 7)
               vm.money_input = 16'hFFF0;
         end
         cyc();
         checks++; if (vm.change !== 16'(m_change)) begin failures++; $display("FAIL rand_change cyc=%0d got=%0d exp=%0d", i, vm.change, m_change); end
         checks++; if (vm.price !== 16'(m_price)) begin failures++; $display("FAIL rand_price cyc=%0d got=%0d exp=%0d", i, vm.price, m_price); end
         checks++; if (vm.selection !== 4'(m_sel)) begin failures++; $display("FAIL rand_selection cyc=%0d got=%0d exp=%0d", i, vm.selection, m_sel); end
         checks++; if (vm.success !== m_succ) begin failures++; $display("FAIL rand_success cyc=%0d got=%0d exp=%0d", i, vm.success, m_succ); end
      end
   endtask

   initial begin
      m_credit = 0; m_row = -1; m_idle = 0; m_last = 0;
      m_change = 0; m_price = 0; m_sel = 0; m_succ = 0; m_rst_prev = 0;
      m_rprev = 4'b0; m_cprev = 4'b0;
      test_reset();
      test_exact_change();
      test_dispense_change();
      test_invalid_selection();
      test_insufficient();
      test_timeout();
      test_reset_refund();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
